// File: rtl/counter_pkg.sv
// Shared types and helpers for the mod_counter block: one-shot state
// encoding, direction constants and a constant-foldable ceil(log2).
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int clog2(input longint unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control and status bundle of mod_counter. The master drives the controls
// and observes the count; the counter itself is the slave.
interface mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             up;
  logic             one_shot;
  logic             start;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] q;
  logic             terminal;
  logic             wrap;
  logic             done;

  modport master (
    output enable, up, one_shot, start, clear, load, load_value,
    input  q, terminal, wrap, done
  );

  modport slave (
    input  enable, up, one_shot, start, clear, load, load_value,
    output q, terminal, wrap, done
  );
endinterface

// File: rtl/mod_prescaler.sv
// Step prescaler for mod_counter: ticks on every PRESCALE-th enable-high
// cycle, holds while enable is low, and restarts from zero on clear.
module mod_prescaler #(
  parameter int PRESCALE = 1,
  parameter int WIDTH    = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Count enable-high cycles modulo PRESCALE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + WIDTH'(1);
  end
endmodule

// File: rtl/mod_counter.sv
// Up/down counter with programmable modulus, parallel load and a one-shot
// mode, used for WS281X splitter bit-slot, pixel-count and frame-gap timing.
// Optional build macro COUNTER_PRESCALE_EN adds a step prescaler (PRESCALE);
// without it every enable-high cycle is a count step.
import counter_pkg::*;

module mod_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter int              PRESCALE = 1
) (
  input  logic           Clock,
  input  logic           Reset,
  mod_counter_if.slave   bus
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "mod_counter: WIDTH must be 2..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "mod_counter: MODULUS must be 2..2**WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $fatal(1, "mod_counter: PRESCALE must be 1..65535");
  end

  // Modulus arithmetic is done one bit wider so MODULUS = 2**WIDTH fits.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic             done, done_nxt;
  logic             wrap, wrap_nxt;
  logic             pre_clr;
  logic             tick;
  logic             step;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] step_q;
  logic             step_wrap;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] term_q;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = clog2(longint'(PRESCALE)) + 1;

  mod_prescaler #(
    .PRESCALE (PRESCALE),
    .WIDTH    (PW)
  ) u_prescaler (
    .Clock  (Clock),
    .Reset  (Reset),
    .enable (bus.enable),
    .clear  (pre_clr),
    .tick   (tick)
  );
`else
  logic unused_pre_clr;
  assign unused_pre_clr = pre_clr;
  assign tick           = 1'b1;
`endif

  assign step   = bus.enable & tick;
  assign up_sum = {1'b0, q} + (WIDTH+1)'(1);
  assign load_q = ({1'b0, bus.load_value} >= MOD_EXT) ? Q_MAX : bus.load_value;
  assign term_q = (bus.up == DIR_UP) ? Q_MAX : '0;

  assign bus.q        = q;
  assign bus.terminal = (q == term_q);
  assign bus.wrap     = wrap;
  assign bus.done     = done;

  // Candidate next count for one step in the current direction, with wrap flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    step_q    = q;
    step_wrap = 1'b0;
    if (bus.up == DIR_UP) begin
      if (up_sum == MOD_EXT) begin
        step_q    = '0;
        step_wrap = 1'b1;
      end else begin
        step_q = up_sum[WIDTH-1:0];
      end
    end else begin
      if (q == '0) begin
        step_q    = Q_MAX;
        step_wrap = 1'b1;
      end else begin
        step_q = q - WIDTH'(1);
      end
    end
  end

  // Next-state and next-output decode: Clear > Load > Start > step.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    done_nxt  = done;
    wrap_nxt  = 1'b0;
    pre_clr   = 1'b0;
    if (bus.clear) begin
      state_nxt = ST_IDLE;
      q_nxt     = '0;
      done_nxt  = 1'b0;
      pre_clr   = 1'b1;
    end else if (bus.load) begin
      q_nxt    = load_q;
      done_nxt = 1'b0;
      pre_clr  = 1'b1;
      if (!bus.one_shot) state_nxt = ST_IDLE;
    end else if (!bus.one_shot) begin
      // Free-run: the one-shot FSM is parked and Done is dropped.
      state_nxt = ST_IDLE;
      done_nxt  = 1'b0;
      if (step) begin
        q_nxt    = step_q;
        wrap_nxt = step_wrap;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state_nxt = ST_RUN;
            done_nxt  = 1'b0;
            pre_clr   = 1'b1;
          end
        end
        ST_RUN: begin
          // A run armed at the terminal value wraps first, then counts to terminal.
          if (step) begin
            q_nxt    = step_q;
            wrap_nxt = step_wrap | (step_q == term_q);
            if (step_q == term_q) begin
              state_nxt = ST_DONE;
              done_nxt  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.start) begin
            state_nxt = ST_RUN;
            q_nxt     = (bus.up == DIR_DOWN) ? Q_MAX : '0;
            done_nxt  = 1'b0;
            pre_clr   = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset clears everything without a Wrap pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      state <= ST_IDLE;
      q     <= '0;
      done  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      done  <= done_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (WIDTH=4, MODULUS=10, PRESCALE=3).
// A driver applies one input vector per cycle and pushes the reference
// model's expected outputs into a scoreboard queue; a monitor pops and
// compares one entry after every rising clock edge.
module tb_mod_counter;

  localparam int W   = 4;
  localparam int MOD = 10;
  localparam int PRE = 3;
`ifdef COUNTER_PRESCALE_EN
  localparam int EFF_PRE = PRE;
`else
  localparam int EFF_PRE = 1;
`endif

  typedef enum int { M_IDLE, M_RUN, M_DONE } mode_t;
  typedef struct {
    int q;
    bit wrap;
    bit done;
    bit term;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(W)) bus ();

  mod_counter #(
    .WIDTH    (W),
    .MODULUS  (MOD),
    .PRESCALE (PRE)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  exp_t  sb[$];
  int    vectors     = 0;
  int    miscompares = 0;

  // Reference model state.
  int    m_q;
  mode_t m_mode;
  bit    m_done;
  int    m_pcnt;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q    = 0;
    m_mode = M_IDLE;
    m_done = 1'b0;
    m_pcnt = 0;
  endtask

  // Drive one cycle of inputs and record what the counter must show after the edge.
  task automatic apply(input bit en, input bit up, input bit os, input bit st,
                       input bit clr, input bit ld, input int lv);
    bit   tick, zero, wrap;
    int   old;
    exp_t e;
    @(negedge clk);
    bus.enable     = en;
    bus.up         = up;
    bus.one_shot   = os;
    bus.start      = st;
    bus.clear      = clr;
    bus.load       = ld;
    bus.load_value = lv[W-1:0];

    tick = en && (m_pcnt == EFF_PRE - 1);
    zero = 1'b0;
    wrap = 1'b0;
    old  = m_q;
    if (clr) begin
      m_q = 0; m_mode = M_IDLE; m_done = 1'b0; zero = 1'b1;
    end else if (ld) begin
      m_q = (lv > MOD - 1) ? MOD - 1 : lv;
      m_done = 1'b0; zero = 1'b1;
      if (!os) m_mode = M_IDLE;
    end else if (!os) begin
      m_mode = M_IDLE; m_done = 1'b0;
      if (tick) begin
        m_q  = up ? (old + 1) % MOD : (old + MOD - 1) % MOD;
        wrap = up ? (old == MOD - 1) : (old == 0);
      end
    end else if (m_mode == M_IDLE) begin
      if (st) begin m_mode = M_RUN; m_done = 1'b0; zero = 1'b1; end
    end else if (m_mode == M_RUN) begin
      if (tick) begin
        m_q = up ? (old + 1) % MOD : (old + MOD - 1) % MOD;
        if (up ? (old == MOD - 1) : (old == 0)) wrap = 1'b1;
        else if (m_q == (up ? MOD - 1 : 0)) begin
          wrap = 1'b1; m_done = 1'b1; m_mode = M_DONE;
        end
      end
    end else begin
      if (st) begin
        m_mode = M_RUN; m_done = 1'b0; m_q = up ? 0 : MOD - 1; zero = 1'b1;
      end
    end
    if (zero)    m_pcnt = 0;
    else if (en) m_pcnt = (m_pcnt + 1) % EFF_PRE;

    e.q    = m_q;
    e.wrap = wrap;
    e.done = m_done;
    e.term = up ? (m_q == MOD - 1) : (m_q == 0);
    sb.push_back(e);
  endtask

  // Monitor: compare one scoreboard entry after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q",        int'(bus.q),        e.q);
        check("wrap",     int'(bus.wrap),     int'(e.wrap));
        check("done",     int'(bus.done),     int'(e.done));
        check("terminal", int'(bus.terminal), int'(e.term));
      end
    end
  end

  initial begin
    int budget;
    bit os, up;
    rst            = 1'b1;
    bus.enable     = 1'b0;
    bus.up         = 1'b1;
    bus.one_shot   = 1'b0;
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q",    int'(bus.q),    0);
    check("reset_wrap", int'(bus.wrap), 0);
    check("reset_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Free-run up through one full cycle, then a frozen stretch.
    for (int i = 0; i < 10 * EFF_PRE; i++) apply(1, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0);
    // Prescale pattern: 9 enabled cycles from zero, then 2 idle cycles.
    apply(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) apply(1, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0);
    // Down from zero wraps to MODULUS-1.
    apply(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < EFF_PRE; i++) apply(1, 0, 0, 0, 0, 0, 0);
    // Load clamping and Load beating Enable.
    apply(0, 1, 0, 0, 0, 1, 15);
    apply(0, 1, 0, 0, 0, 1, 3);
    apply(1, 1, 0, 0, 0, 1, 7);
    // One-shot up from zero, then hold at the terminal value.
    apply(0, 1, 1, 0, 1, 0, 0);
    apply(0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 13 * EFF_PRE; i++) apply(1, 1, 1, 0, 0, 0, 0);
    // Re-arm from DONE counting down, run to zero.
    apply(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 11 * EFF_PRE; i++) apply(1, 0, 1, 0, 0, 0, 0);

    // Reset between clock edges in the middle of a one-shot run at Q=5.
    apply(0, 1, 1, 0, 1, 0, 0);
    apply(0, 1, 1, 1, 0, 0, 0);
    budget = 0;
    while (m_q != 5 && budget < 100) begin
      apply(1, 1, 1, 0, 0, 0, 0);
      budget++;
    end
    check("reach_q5", m_q, 5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_q",    int'(bus.q),    0);
    check("async_reset_done", int'(bus.done), 0);
    check("async_reset_wrap", int'(bus.wrap), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3 * EFF_PRE; i++) apply(1, 1, 1, 0, 0, 0, 0);

    // Randomized phase.
    os = 1'b0;
    up = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) os = ~os;
      if ($urandom_range(0, 7) == 0)  up = ~up;
      apply($urandom_range(0, 3) != 0, up, os,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 79) == 0,
            $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 15)));
    end

    budget = 0;
    while (sb.size() > 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
